// File: rtl/layer_output_serializer.sv
// Serializes one layer's parallel neuron outputs into a burst of numNeuron beats,
// with a mandatory idle cycle between bursts and a one-frame pending buffer.
//
// state | meaning
// IDLE  | no burst in progress, waiting for x_valid
// SHIFT | emitting one beat per cycle from sreg
// GAP   | single valid-low cycle separating bursts
module layer_output_serializer #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           x_valid,
  input  logic [numNeuron*dataWidth-1:0] x_in,
  output logic [dataWidth-1:0]           data_out,
  output logic                           data_out_valid,
  output logic                           data_out_last,
  output logic                           busy,
  output logic                           overflow
);

  localparam int FW = numNeuron * dataWidth;
  localparam int CW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(numNeuron - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   sreg_q, sreg_d;
  logic [FW-1:0]   pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            overflow_q, overflow_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (x_valid) begin
          sreg_d  = x_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = sreg_q >> dataWidth;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = GAP;
        // A frame arriving mid-burst waits in pend; a second one is lost.
        if (x_valid) begin
          if (!pend_full_q) begin
            pend_d      = x_in;
            pend_full_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (pend_full_q) begin
          sreg_d  = pend_q;
          cnt_d   = '0;
          state_d = SHIFT;
          if (x_valid) pend_d = x_in;
          else         pend_full_d = 1'b0;
        end else if (x_valid) begin
          sreg_d  = x_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out       = sreg_q[dataWidth-1:0];
  assign data_out_valid = (state_q == SHIFT);
  assign data_out_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign busy           = (state_q != IDLE) || pend_full_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: frame-schedule model for numNeuron=4 plus
// literal expectations from the directed scenarios, and a numNeuron=1 instance.
module tb_layer_output_serializer;
  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            x_valid;
  logic [N*DW-1:0] x_in;
  logic [DW-1:0]   data_out;
  logic            data_out_valid, data_out_last, busy, overflow;

  logic            x1_valid;
  logic [DW-1:0]   x1_in;
  logic [DW-1:0]   d1_out;
  logic            d1_valid, d1_last, d1_busy, d1_overflow;

  layer_output_serializer #(.numNeuron(N), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_last(data_out_last), .busy(busy), .overflow(overflow)
  );

  layer_output_serializer #(.numNeuron(1), .dataWidth(DW)) dut1 (
    .clk(clk), .rst(rst), .x_valid(x1_valid), .x_in(x1_in),
    .data_out(d1_out), .data_out_valid(d1_valid),
    .data_out_last(d1_last), .busy(d1_busy), .overflow(d1_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each accepted frame gets an arrival cycle and a first-beat cycle.
  typedef struct {
    int              arr;
    int              start;
    logic [N*DW-1:0] data;
  } frame_t;

  frame_t        fq[$];
  frame_t        nf;
  bit            m_ovf = 0;
  logic          m_v, m_l, m_b;
  logic [DW-1:0] m_d;
  bit            waiting;
  int            st;

  always @(negedge clk) begin
    m_v = 0; m_l = 0; m_b = 0; m_d = '0;
    foreach (fq[i]) begin
      if (cyc >= fq[i].start && cyc < fq[i].start + N) begin
        m_v = 1;
        m_d = fq[i].data[(cyc - fq[i].start)*DW +: DW];
        m_l = (cyc == fq[i].start + N - 1);
      end
      if (fq[i].arr < cyc && cyc <= fq[i].start + N) m_b = 1;
    end
    if (chk_en) begin
      chk("model_valid", 64'(data_out_valid), 64'(m_v));
      chk("model_data", 64'(data_out), 64'(m_d));
      chk("model_last", 64'(data_out_last), 64'(m_l));
      chk("model_busy", 64'(busy), 64'(m_b));
      chk("model_overflow", 64'(overflow), 64'(m_ovf));
    end
    if (rst) begin
      fq.delete();
      m_ovf = 0;
    end else if (x_valid) begin
      waiting = 0;
      foreach (fq[i]) if (fq[i].start > cyc + 1) waiting = 1;
      if (waiting) m_ovf = 1;
      else begin
        st = cyc + 1;
        if (fq.size() > 0 && fq[fq.size()-1].start + N + 1 > st)
          st = fq[fq.size()-1].start + N + 1;
        nf.arr = cyc; nf.start = st; nf.data = x_in;
        fq.push_back(nf);
      end
    end
    while (fq.size() > 0 && fq[0].start + N <= cyc) void'(fq.pop_front());
  end

  function automatic logic [N*DW-1:0] mk(input logic [DW-1:0] b);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    rst = 0; x_valid = 0; x_in = '0; x1_valid = 0; x1_in = '0;
  endtask

  task automatic do_reset();
    step();
    rst = 1;
    step();
  endtask

  initial begin
    rst = 1; x_valid = 0; x_in = '0; x1_valid = 0; x1_in = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_data", 64'(data_out), 64'h0);
    chk("rst_valid", 64'(data_out_valid), 64'h0);
    chk("rst_last", 64'(data_out_last), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_n1_valid", 64'(d1_valid), 64'h0);
    chk_en = 1;
    step();

    // Single frame at k=5
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 5) begin x_valid = 1; x_in = mk(16'h0001); end
      @(negedge clk);
      if (k >= 6 && k <= 9) begin
        chk("single_data", 64'(data_out), 64'(k - 5));
        chk("single_valid", 64'(data_out_valid), 64'h1);
      end
      if (k >= 6 && k <= 10) chk("single_last", 64'(data_out_last), 64'(k == 9));
      if (k == 10) chk("single_gap_busy", 64'(busy), 64'h1);
      if (k == 10) chk("single_gap_valid", 64'(data_out_valid), 64'h0);
      if (k == 11) chk("single_busy_fall", 64'(busy), 64'h0);
    end

    // Back-to-back: A at 0, B at 2
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 0) begin x_valid = 1; x_in = mk(16'h0010); end
      if (k == 2) begin x_valid = 1; x_in = mk(16'h0020); end
      @(negedge clk);
      if (k == 1) chk("b2b_a0", 64'(data_out), 64'h10);
      if (k == 4) chk("b2b_a3", 64'(data_out), 64'h13);
      if (k == 5) chk("b2b_gap_valid", 64'(data_out_valid), 64'h0);
      if (k == 6) chk("b2b_b0", 64'(data_out), 64'h20);
      if (k == 9) chk("b2b_b3_last", 64'(data_out_last), 64'h1);
      if (k == 12) chk("b2b_overflow", 64'(overflow), 64'h0);
    end

    // Overflow: A, B, C at 0, 1, 2
    for (int k = 0; k < 16; k++) begin
      step();
      if (k <= 2) begin x_valid = 1; x_in = mk(16'h0100 * 16'(k + 1)); end
      @(negedge clk);
      if (k == 2) chk("ovf_before", 64'(overflow), 64'h0);
      if (k == 3) chk("ovf_set", 64'(overflow), 64'h1);
      if (k == 6) chk("ovf_b0", 64'(data_out), 64'h0200);
      if (k == 11) chk("ovf_no_c", 64'(data_out_valid), 64'h0);
      if (k == 15) chk("ovf_sticky", 64'(overflow), 64'h1);
    end
    do_reset();
    @(negedge clk);
    chk("ovf_cleared", 64'(overflow), 64'h0);

    // x_valid in GAP with pending full: A 0, B 1, C 5
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 0) begin x_valid = 1; x_in = mk(16'h1000); end
      if (k == 1) begin x_valid = 1; x_in = mk(16'h2000); end
      if (k == 5) begin x_valid = 1; x_in = mk(16'h3000); end
      @(negedge clk);
      if (k == 6) chk("gap_b0", 64'(data_out), 64'h2000);
      if (k == 10) chk("gap_valid", 64'(data_out_valid), 64'h0);
      if (k == 11) chk("gap_c0", 64'(data_out), 64'h3000);
      if (k == 14) chk("gap_c3", 64'(data_out), 64'h3003);
      if (k == 15) chk("gap_overflow", 64'(overflow), 64'h0);
    end

    // Reset mid-burst: A 0, B 1, rst at 3
    for (int k = 0; k < 14; k++) begin
      step();
      if (k == 0) begin x_valid = 1; x_in = mk(16'h4000); end
      if (k == 1) begin x_valid = 1; x_in = mk(16'h5000); end
      if (k == 3) rst = 1;
      @(negedge clk);
      if (k == 2) chk("rst_mid_beat", 64'(data_out), 64'h4001);
      if (k == 4) begin
        chk("rst_mid_data", 64'(data_out), 64'h0);
        chk("rst_mid_busy", 64'(busy), 64'h0);
        chk("rst_mid_last", 64'(data_out_last), 64'h0);
      end
      if (k >= 4) chk("rst_mid_quiet", 64'(data_out_valid), 64'h0);
    end

    // x_valid on last beat, then again in GAP with pending full
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 0) begin x_valid = 1; x_in = mk(16'h6000); end
      if (k == 4) begin x_valid = 1; x_in = mk(16'h7000); end
      if (k == 5) begin x_valid = 1; x_in = mk(16'h8000); end
      @(negedge clk);
      if (k == 6) chk("lastbeat_b0", 64'(data_out), 64'h7000);
      if (k == 11) chk("lastbeat_c0", 64'(data_out), 64'h8000);
    end

    // numNeuron=1 instance
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) begin x1_valid = 1; x1_in = 16'hBEEF; end
      @(negedge clk);
      if (k == 1) begin
        chk("n1_data", 64'(d1_out), 64'hBEEF);
        chk("n1_valid", 64'(d1_valid), 64'h1);
        chk("n1_last", 64'(d1_last), 64'h1);
      end
      if (k == 2) begin
        chk("n1_gap_valid", 64'(d1_valid), 64'h0);
        chk("n1_gap_busy", 64'(d1_busy), 64'h1);
      end
      if (k == 3) chk("n1_idle_busy", 64'(d1_busy), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer_output_serializer.md
# layer_output_serializer

Converts the parallel outputs of one layer's neurons into the serial value stream that the next layer's neurons consume on their `myinput`/`myinputValid` pair. It sits between layer k's neuron array, whose neurons all raise `outvalid` in the same cycle, and layer k+1's neuron inputs.

- Each captured frame is emitted as one contiguous burst of `numNeuron` beats.
- Consecutive bursts are separated by at least one idle cycle. Downstream neurons detect end-of-stream on the falling edge of valid, so this gap is mandatory.
- One pending frame is buffered so that a new layer output arriving mid-burst is not lost.

## Interface
Parameters:
- `numNeuron`, default 30: neurons in the feeding layer, which is also the beats per burst. Must be ≥1.
- `dataWidth`, default 16: width of one neuron output.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `x_valid`, in, 1: one-cycle strobe. The feeding layer's outputs are valid on `x_in`.
- `x_in`, in, `numNeuron*dataWidth`: neuron i occupies `[i*dataWidth +: dataWidth]`.
- `data_out`, out, `dataWidth`: current serial value. Equals `sreg[dataWidth-1:0]`.
- `data_out_valid`, out, 1: beat valid. Drives the next layer's `myinputValid`.
- `data_out_last`, out, 1: high on the final beat of a burst.
- `busy`, out, 1: high when state≠IDLE or `pend_full`=1.
- `overflow`, out, 1: sticky. Set when a frame is dropped; cleared only by `rst`.

## Operation
Internal registers:
- `sreg`: `numNeuron*dataWidth`-bit shift register.
- `pend`: `numNeuron*dataWidth`-bit pending frame.
- `pend_full`: pending-frame flag.
- `cnt`: beat counter, width `max(1,$clog2(numNeuron))`.
- `state`: IDLE, SHIFT or GAP.

Values pass through unmodified. There is no arithmetic on data.

State behaviour:
- **IDLE**
  - `data_out_valid`=0.
  - On `x_valid`: `sreg`←`x_in`, `cnt`←0, go to SHIFT.
- **SHIFT**
  - `data_out_valid`=1 and `data_out`=`sreg[dataWidth-1:0]`.
  - Each cycle: `sreg`←`sreg>>dataWidth`, `cnt`←`cnt+1`.
  - When `cnt==numNeuron-1`: `data_out_last`=1, and the next state is GAP.
- **GAP**
  - `data_out_valid`=0 for exactly this cycle.
  - If `pend_full`: `sreg`←`pend`, `cnt`←0, go to SHIFT. `pend_full`←0, unless `x_valid` is also high this cycle, in which case `pend`←`x_in` and `pend_full` stays 1.
  - Otherwise, if `x_valid`: `sreg`←`x_in`, `cnt`←0, go to SHIFT.
  - Otherwise go to IDLE.

Handling of `x_valid` during SHIFT:
- If `pend_full`=0: `pend`←`x_in`, `pend_full`←1.
- If `pend_full`=1: the new frame is dropped, `pend` is kept, and `overflow`←1.

Boundary conditions:
- **`numNeuron`=1:** the burst is one beat, with `data_out_valid` and `data_out_last` high together.
- **`x_valid` on the last SHIFT beat:** follows the SHIFT rule above (stored if there is room, else dropped).
- **`rst` mid-burst:** abort immediately. The next cycle is IDLE with all outputs 0, and the pending frame is discarded.
- **Ordering:** frames are emitted strictly in arrival order. With one-entry buffering, the oldest accepted frames win.

## Timing
- Reset values: `data_out`=0 (`sreg` cleared), `data_out_valid`=0, `data_out_last`=0, `busy`=0, `overflow`=0, `pend_full`=0, state IDLE.
- Latency: with `x_valid` at cycle T in IDLE, neuron i appears on `data_out` at T+1+i (i=0..`numNeuron-1`), and `data_out_last` is high at T+`numNeuron`.
- Minimum frame period is `numNeuron+1` cycles: `numNeuron` beats plus one GAP cycle.
- Valid is never deasserted mid-burst. There are no stalls and no backpressure input.
- All outputs are registered or taken directly from registers. `data_out_last` and `busy` are decoded from registered state only.

## Test plan
Unless stated otherwise, `numNeuron`=4 and `dataWidth`=16.

- **Single frame:** `x_valid` at cycle 5 with `x_in`={16'h0004,16'h0003,16'h0002,16'h0001}.
  - `data_out` = 1,2,3,4 at cycles 6-9 with valid high.
  - `last` high at cycle 9 only.
  - `busy` falls at cycle 11 (GAP at 10, then IDLE).
- **Back-to-back frames:** frame A at cycle 0, frame B at cycle 2.
  - A beats at cycles 1-4.
  - Valid low at cycle 5.
  - B beats at cycles 6-9.
  - `overflow`=0.
- **Overflow:** frames A, B and C at cycles 0, 1 and 2.
  - A then B are emitted, B starting at cycle 6.
  - C never appears.
  - `overflow`=1 from cycle 3 and stays set until `rst`.
- **`x_valid` in GAP with pending full:** A at cycle 0, B at cycle 1, C at cycle 5.
  - B is emitted at cycles 6-9.
  - C is emitted at cycles 11-14.
  - `overflow`=0.
- **Reset mid-burst:** `rst` at cycle 3 during A, with B pending.
  - At cycle 4: all outputs 0, IDLE.
  - No beats are emitted afterwards until a new `x_valid`.
- **`numNeuron`=1:** `x_valid` at cycle 0 with `x_in`=16'hBEEF.
  - Cycle 1: `data_out`=16'hBEEF, with `data_out_valid` and `data_out_last` both high.
  - Cycle 2: GAP. Cycle 3: IDLE.
